// File: rtl/axis_read_arbiter.sv
// Round-robin share of one AXI AR/R port among NUM_PORTS in-order read engines; grants 0-cycle, m_arvalid one cycle after accept.
// Grants stall while the burst-order queue is full or an AR is pending issue; R beats stall when the owning engine drops s_rready.
module axis_read_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int ORDER_AWIDTH   = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_PORTS-1:0]                s_arvalid,
  input  logic [NUM_PORTS*AXI_ADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_PORTS*8-1:0]              s_arlen,
  output logic [NUM_PORTS-1:0]                s_arready,
  output logic [AXI_DATA_WIDTH-1:0]           s_rdata,
  output logic [NUM_PORTS-1:0]                s_rvalid,
  input  logic [NUM_PORTS-1:0]                s_rready,
  output logic [AXI_ADDR_WIDTH-1:0]           m_araddr,
  output logic [7:0]                          m_arlen,
  output logic                                m_arvalid,
  input  logic                                m_arready,
  input  logic [AXI_DATA_WIDTH-1:0]           m_rdata,
  input  logic                                m_rvalid,
  output logic                                m_rready,
  output logic                                busy
);

  localparam int PW    = (NUM_PORTS > 2) ? 2 : 1;
  localparam int DEPTH = 1 << ORDER_AWIDTH;
  localparam logic [ORDER_AWIDTH:0] OCC_MAX   = (ORDER_AWIDTH+1)'(DEPTH);
  localparam logic [PW-1:0]         LAST_PORT = PW'(NUM_PORTS - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]                r_state;
  logic [PW-1:0]             r_ptr;
  logic [PW-1:0]             r_owner;
  logic [ORDER_AWIDTH:0]     r_occ;
  logic [AXI_ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]                r_arlen;

  logic [PW-1:0]             r_q_owner [DEPTH];
  logic [7:0]                r_q_len   [DEPTH];
  logic [ORDER_AWIDTH-1:0]   r_wr_ptr;
  logic [ORDER_AWIDTH-1:0]   r_rd_ptr;
  logic [ORDER_AWIDTH:0]     r_q_cnt;
  logic [7:0]                r_beat;

  logic                      w_win_vld;
  logic [PW-1:0]             w_win;
  logic [AXI_ADDR_WIDTH-1:0] w_sel_addr;
  logic [7:0]                w_sel_len;
  logic                      w_accept;
  logic                      w_push;
  logic                      w_q_empty;
  logic [PW-1:0]             w_head_owner;
  logic [7:0]                w_head_len;
  logic                      w_m_rready;
  logic                      w_r_hs;
  logic                      w_pop;

  // Search upward from the priority pointer, wrapping modulo NUM_PORTS.
  always_comb begin
    logic [PW:0] w_sum;
    w_win_vld = 1'b0;
    w_win     = '0;
    w_sum     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(NUM_PORTS)) begin
        w_sum = w_sum - (PW+1)'(NUM_PORTS);
      end
      if (!w_win_vld && s_arvalid[w_sum[PW-1:0]]) begin
        w_win_vld = 1'b1;
        w_win     = w_sum[PW-1:0];
      end
    end
  end

  always_comb begin
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (w_win == PW'(k)) begin
        w_sel_addr = s_araddr[k*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        w_sel_len  = s_arlen[k*8 +: 8];
      end
    end
  end

  // Occupancy counts the burst held in ISSUE, so a later push always has a slot.
  assign w_accept = rst_n && (r_state == ST_IDLE) && (r_occ < OCC_MAX) && w_win_vld;
  assign w_push   = (r_state == ST_ISSUE) && m_arready;

  always_comb begin
    s_arready = '0;
    if (w_accept) begin
      s_arready[w_win] = 1'b1;
    end
  end

  assign w_q_empty    = (r_q_cnt == '0);
  assign w_head_owner = r_q_owner[r_rd_ptr];
  assign w_head_len   = r_q_len[r_rd_ptr];
  assign w_m_rready   = !w_q_empty && s_rready[w_head_owner];
  assign w_r_hs       = m_rvalid && w_m_rready;
  assign w_pop        = w_r_hs && (r_beat == w_head_len);

  always_comb begin
    s_rvalid = '0;
    if (!w_q_empty) begin
      s_rvalid[w_head_owner] = m_rvalid;
    end
  end

  assign m_rready  = w_m_rready;
  assign s_rdata   = m_rdata;
  assign m_arvalid = (r_state == ST_ISSUE);
  assign m_araddr  = r_araddr;
  assign m_arlen   = r_arlen;
  assign busy      = (r_occ != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_araddr <= '0;
      r_arlen  <= '0;
    end else if (w_accept) begin
      r_state  <= ST_ISSUE;
      r_araddr <= w_sel_addr;
      r_arlen  <= w_sel_len;
      r_owner  <= w_win;
      r_ptr    <= (w_win == LAST_PORT) ? '0 : w_win + PW'(1);
    end else if (w_push) begin
      r_state  <= ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      unique case ({w_accept, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_q_cnt  <= '0;
      r_beat   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_owner[i] <= '0;
        r_q_len[i]   <= '0;
      end
    end else begin
      if (w_push) begin
        r_q_owner[r_wr_ptr] <= r_owner;
        r_q_len[r_wr_ptr]   <= r_arlen;
        r_wr_ptr            <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_q_cnt <= r_q_cnt + 1'b1;
        2'b01:   r_q_cnt <= r_q_cnt - 1'b1;
        default: r_q_cnt <= r_q_cnt;
      endcase
      if (w_pop) begin
        r_beat <= '0;
      end else if (w_r_hs) begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

endmodule

// File: doc/axis_read_arbiter.md
Name: axis_read_arbiter

Overview:
- Shares one AXI read-address (AR) channel and one AXI read-data (R) channel among NUM_PORTS axis_read engines.
- Round-robin arbitration on AR requests; ownership of each granted burst is queued in order.
- R beats are steered to the queued owner and counted against that burst's arlen.
- Sits between the axis_read instances and the single AXI HP read port. Assumes an in-order slave with no AXI IDs.

Parameters:
- NUM_PORTS, 2, number of requesting engines (2..4)
- AXI_ADDR_WIDTH, 32, AR address width
- AXI_DATA_WIDTH, 256, R data width
- ORDER_AWIDTH, 2, log2 depth of the burst-order queue (max outstanding bursts = 2**ORDER_AWIDTH)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_arvalid  in  NUM_PORTS  per-engine AR request
- s_araddr  in  NUM_PORTS*AXI_ADDR_WIDTH  per-engine address; port k at bits [k*AW +: AW]
- s_arlen  in  NUM_PORTS*8  per-engine burst length-1; port k at [k*8 +: 8]
- s_arready  out  NUM_PORTS  per-engine AR accept
- s_rdata  out  AXI_DATA_WIDTH  broadcast copy of m_rdata
- s_rvalid  out  NUM_PORTS  per-engine R valid
- s_rready  in  NUM_PORTS  per-engine R ready
- m_araddr  out  AXI_ADDR_WIDTH  AR address to memory
- m_arlen  out  8  AR burst length-1
- m_arvalid  out  1  AR valid
- m_arready  in  1  AR ready
- m_rdata  in  AXI_DATA_WIDTH  R data
- m_rvalid  in  1  R valid
- m_rready  out  1  R ready
- busy  out  1  high while any burst is accepted but not fully returned

Behaviour:
- Reset: rst_n low asynchronously clears the following:
  - m_arvalid=0, m_araddr=0, m_arlen=0
  - priority pointer=0, occupancy=0, queue empty, beat counter=0
  - s_arready, s_rvalid and m_rready therefore 0; busy=0
- Reset mid-burst discards all outstanding bursts. Engines and the slave must be reset together.
- AR FSM, two states:
  - IDLE: accept allowed when occupancy < 2**ORDER_AWIDTH.
    - Winner = first k with s_arvalid[k], searching from the priority pointer upward (mod NUM_PORTS).
    - s_arready[winner]=1 combinationally in that cycle; all other bits 0.
    - On accept: latch s_araddr/s_arlen of the winner into m_araddr/m_arlen, record owner, increment occupancy, pointer = winner+1 mod NUM_PORTS, go to ISSUE.
  - ISSUE: m_arvalid=1 with stable address and length.
    - On m_arvalid&m_arready: push {owner, arlen} to the order queue, return to IDLE.
    - s_arready is all-zero in ISSUE.
- AR latency: accept in cycle t -> m_arvalid from cycle t+1. Minimum spacing is one accepted request every 2 cycles.
- R steering (head of order queue = current owner o, length L):
  - Queue empty: m_rready=0, s_rvalid=0.
  - Otherwise: s_rvalid[o]=m_rvalid, other bits 0; m_rready=s_rready[o]; s_rdata=m_rdata always.
  - Beat counter increments on each m_rvalid&m_rready.
  - When a handshake occurs with counter==L: pop the queue, clear the counter, decrement occupancy.
- Simultaneous events:
  - Accept and last-beat pop in the same cycle leave occupancy unchanged.
  - Queue push and pop in the same cycle are legal.
  - A push never hits a full queue, because occupancy reserves the slot at accept.
- Full: with occupancy at max, no s_arready is asserted; pending s_arvalid is held by the engines.
- busy = (occupancy != 0).
- Counter width is 8 bits; arlen=255 means 256 beats, and wrap is unreachable.

Test Plan:
- Single request: port0 araddr=0x100, arlen=0 with m_arready=1 -> s_arready[0] for 1 cycle; m_arvalid next cycle with 0x100/0; one R beat -> s_rvalid[0] only; busy falls after the beat.
- Contention: ports 0 and 1 assert continuously, arlen=1 each -> grant order 0,1,0,1; queue holds owners in that order; R beats 1-2 go to port 0, beats 3-4 to port 1.
- Backpressure: the burst owner (port 1) drops s_rready for 3 cycles mid-burst while m_rvalid=1 -> m_rready=0 for those cycles, no beat lost, beat counter holds.
- Full queue (ORDER_AWIDTH=2): 4 accepted bursts with no R returned -> the 5th s_arvalid gets no s_arready until one burst's last beat, then it is accepted.
- AR stall: m_arready=0 for 5 cycles -> m_arvalid, m_araddr and m_arlen stay stable and s_arready stays 0; the push happens on the handshake cycle.
- Async reset with 2 bursts outstanding: assert rst_n low between clock edges -> m_arvalid, s_rvalid, m_rready and busy go to 0 immediately; the next grant goes to port 0.
